// File: rtl/servant_uart_tx_if.sv
// Wishbone-style peripheral bus bundle for the servant UART transmitter.
// The slave modport is the peripheral side; the master modport is the CPU/bus side.
interface servant_uart_tx_if;
  logic        i_wb_adr;
  logic [31:0] i_wb_dat;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport slave (
    input  i_wb_adr,
    input  i_wb_dat,
    input  i_wb_we,
    input  i_wb_cyc,
    output o_wb_rdt,
    output o_wb_ack
  );

  modport master (
    output i_wb_adr,
    output i_wb_dat,
    output i_wb_we,
    output i_wb_cyc,
    input  o_wb_rdt,
    input  o_wb_ack
  );
endinterface

// File: rtl/servant_uart_tx.sv
// Buffered Wishbone UART transmitter: TX FIFO, programmable baud divisor,
// start/data/stop framing FSM driving a registered, idle-high serial line.
module servant_uart_tx #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 278
) (
  input  logic               wb_clk,
  input  logic               wb_rst_n,
  servant_uart_tx_if.slave   wb,
  output logic               o_q
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic                 ack_q,   ack_d;
  logic [31:0]          rdt_q,   rdt_d;
  logic                 ovf_q,   ovf_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wptr_q,  wptr_d;
  logic [PTR_W-1:0]     rptr_q,  rptr_d;
  logic [DIV_WIDTH-1:0] div_q,   div_d;
  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q,   cnt_d;
  logic [DIV_WIDTH-1:0] dlat_q,  dlat_d;
  logic [IDX_W-1:0]     bidx_q,  bidx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q,   txd_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                 bus_hit;
  logic                 wr_data;
  logic                 rd_status;
  logic                 wr_div;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 busy;
  logic                 pop;
  logic                 push;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [31:0]          status;
  logic                 unused_dat;

  assign unused_dat = ^wb.i_wb_dat;

  // A new access is accepted only while ack is low, so a held cyc acks every other cycle.
  assign bus_hit   = wb.i_wb_cyc & ~ack_q;
  assign wr_data   = bus_hit &  wb.i_wb_we & ~wb.i_wb_adr;
  assign rd_status = bus_hit & ~wb.i_wb_we & ~wb.i_wb_adr;
  assign wr_div    = bus_hit &  wb.i_wb_we &  wb.i_wb_adr;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign busy       = (state_q != S_IDLE) | ~fifo_empty;
  assign div_eff    = (div_q == '0) ? DIV_WIDTH'(1) : div_q;

  assign status = {16'h0000, 8'(count_q), 4'h0, ovf_q, fifo_full, fifo_empty, busy};

  // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
  assign push = wr_data & (~fifo_full | pop);

  // Bus response and register file next-state
  always_comb begin
    ack_d = bus_hit;
    rdt_d = '0;
    div_d = div_q;
    ovf_d = ovf_q;
    if (bus_hit && !wb.i_wb_we) begin
      rdt_d = wb.i_wb_adr ? 32'(div_q) : status;
    end
    if (wr_div) begin
      div_d = wb.i_wb_dat[DIV_WIDTH-1:0];
    end
    if (rd_status) begin
      ovf_d = 1'b0;
    end
    if (wr_data && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Framing FSM: divisor is latched per frame, back-to-back frames skip IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dlat_d  = dlat_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          dlat_d  = div_eff;
          cnt_d   = div_eff - DIV_WIDTH'(1);
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          cnt_d   = dlat_q - DIV_WIDTH'(1);
          bidx_d  = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = dlat_q - DIV_WIDTH'(1);
          shift_d = shift_q >> 1;
          if (bidx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = S_STOP;
          end else begin
            bidx_d = bidx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            dlat_d  = div_eff;
            cnt_d   = div_eff - DIV_WIDTH'(1);
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level follows the current state one cycle later, uniformly for every bit
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q   <= 1'b0;
      rdt_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      div_q   <= DIV_WIDTH'(DEFAULT_DIV);
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dlat_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      ack_q   <= ack_d;
      rdt_q   <= rdt_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      div_q   <= div_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dlat_q  <= dlat_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // FIFO storage carries no reset; occupancy alone defines validity
  always_ff @(posedge wb_clk) begin
    if (push) begin
      mem_q[wptr_q] <= wb.i_wb_dat[DATA_BITS-1:0];
    end
  end

  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_rdt = rdt_q;
  assign o_q         = txd_q;

endmodule

// File: tb/tb_servant_uart_tx.sv
// Scoreboard bench for servant_uart_tx: stimulus queues expected frames,
// a line monitor decodes every frame cycle-exactly and compares.
module tb_servant_uart_tx;
  localparam int DB = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic o_q;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc_cnt = 0;
  bit   in_frame = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         contig;
    bit         abort;
  } exp_t;

  exp_t exp_q[$];

  servant_uart_tx_if wb ();

  servant_uart_tx dut (
    .wb_clk   (clk),
    .wb_rst_n (rst_n),
    .wb       (wb),
    .o_q      (o_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic wb_xfer(input logic adr, input logic we, input logic [31:0] dat,
                         output logic [31:0] rd);
    bit got;
    @(negedge clk);
    wb.i_wb_adr = adr;
    wb.i_wb_we  = we;
    wb.i_wb_dat = dat;
    wb.i_wb_cyc = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (wb.o_wb_ack) got = 1'b1;
    end
    rd = wb.o_wb_rdt;
    wb.i_wb_cyc = 1'b0;
    wb.i_wb_we  = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 8 cycles");
    end
  endtask

  task automatic wr(input logic adr, input logic [31:0] dat);
    logic [31:0] dummy;
    wb_xfer(adr, 1'b1, dat, dummy);
  endtask

  task automatic rd_check(input string name, input logic adr, input logic [31:0] expv);
    logic [31:0] r;
    wb_xfer(adr, 1'b0, 32'h0, r);
    check(name, r, expv);
  endtask

  task automatic send(input logic [7:0] d, input int div, input bit contig, input bit abort);
    exp_t e;
    e.data = d; e.div = div; e.contig = contig; e.abort = abort;
    exp_q.push_back(e);
    wr(1'b0, {24'h0, d});
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      if (exp_q.size() == 0 && !in_frame) done = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: got %0d frames pending expected 0 within %0d cycles",
               name, exp_q.size(), max_cyc);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int div, input int k);
    int idx;
    logic [7:0] dv;
    idx = k / div;
    dv  = d;
    if (idx == 0) return 1'b0;
    if (idx <= DB) return dv[idx-1];
    return 1'b1;
  endfunction

  // Line monitor: each falling edge from idle or a stop bit starts a frame
  initial begin
    int prev_end;
    prev_end = -1;
    forever begin
      @(negedge clk);
      if (rst_n && o_q === 1'b0) begin
        in_frame = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got start at cycle %0d expected idle line", cyc_cnt);
          for (int i = 0; i < 20000 && o_q === 1'b0; i++) @(negedge clk);
        end else begin
          exp_t e;
          int   s, len, bad;
          bit   aborted;
          e       = exp_q.pop_front();
          s       = cyc_cnt;
          len     = (DB + 2) * e.div;
          bad     = 0;
          aborted = 1'b0;
          if (e.contig) check("frame_contiguous_start", s, prev_end);
          for (int k = 1; k < len; k++) begin
            @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            if (o_q !== exp_bit(e.data, e.div, k)) bad++;
          end
          checks++;
          if (bad != 0 || aborted != e.abort) begin
            errors++;
            $display("FAIL frame_0x%02h_div%0d: got %0d bad cycles aborted=%0d expected 0 bad aborted=%0d",
                     e.data, e.div, bad, aborted, e.abort);
          end
          prev_end = s + len;
        end
        in_frame = 1'b0;
      end
    end
  end

  initial begin
    wb.i_wb_adr = 1'b0;
    wb.i_wb_dat = 32'h0;
    wb.i_wb_we  = 1'b0;
    wb.i_wb_cyc = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_o_q", 32'(o_q), 32'h1);
    check("rst_ack", 32'(wb.o_wb_ack), 32'h0);
    check("rst_rdt", wb.o_wb_rdt, 32'h0);
    rst_n = 1'b1;
    rd_check("rst_status", 1'b0, 32'h0000_0002);
    rd_check("rst_divisor", 1'b1, 32'd278);

    // Default divisor, 0x55, start bit two edges after the ack edge
    send(8'h55, 278, 1'b0, 1'b0);
    @(negedge clk);
    check("latency_edge1_high", 32'(o_q), 32'h1);
    @(negedge clk);
    check("latency_edge2_low", 32'(o_q), 32'h0);
    wait_done("t1_frame_done", 3500);
    rd_check("t1_status_idle", 1'b0, 32'h0000_0002);

    // Divisor 4, three back-to-back frames with no idle gap
    wr(1'b1, 32'd4);
    send(8'hA3, 4, 1'b0, 1'b0);
    send(8'h0F, 4, 1'b1, 1'b0);
    send(8'hFF, 4, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    rd_check("t2_status_busy_empty", 1'b0, 32'h0000_0003);
    wait_done("t2_frames_done", 500);
    rd_check("t2_status_idle", 1'b0, 32'h0000_0002);

    // Long frame stalls the FSM while the FIFO overflows
    wr(1'b1, 32'd1000);
    send(8'hA5, 1000, 1'b0, 1'b0);
    wr(1'b1, 32'd1);
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1, 1'b1, 1'b0);
    wr(1'b0, 32'h0000_00EE);
    rd_check("t3_status_full_ovf", 1'b0, 32'h0000_100D);
    rd_check("t3_status_ovf_cleared", 1'b0, 32'h0000_1005);
    wait_done("t3_frames_done", 11000);
    rd_check("t3_status_idle", 1'b0, 32'h0000_0002);

    // Divisor 0 behaves as 1
    wr(1'b1, 32'd0);
    rd_check("t4_divisor_zero_readback", 1'b1, 32'h0);
    send(8'h01, 1, 1'b0, 1'b0);
    wait_done("t4_frame_done", 100);

    // Mid-frame divisor change only affects the following frame
    wr(1'b1, 32'd8);
    send(8'h3C, 8, 1'b0, 1'b0);
    send(8'hC3, 16, 1'b1, 1'b0);
    wr(1'b1, 32'd16);
    rd_check("t5_divisor_readback", 1'b1, 32'd16);
    wait_done("t5_frames_done", 400);

    // Reset in the middle of a data bit, with a second byte still queued
    wr(1'b1, 32'd8);
    send(8'hF0, 8, 1'b0, 1'b1);
    wr(1'b0, 32'h0000_000F);
    repeat (36) @(negedge clk);
    wb.i_wb_adr = 1'b0;
    wb.i_wb_we  = 1'b0;
    wb.i_wb_cyc = 1'b1;
    @(posedge clk);
    #1;
    check("t6_ack_before_reset", 32'(wb.o_wb_ack), 32'h1);
    check("t6_line_low_before_reset", 32'(o_q), 32'h0);
    rst_n = 1'b0;
    #1;
    check("t6_reset_o_q", 32'(o_q), 32'h1);
    check("t6_reset_ack", 32'(wb.o_wb_ack), 32'h0);
    check("t6_reset_rdt", wb.o_wb_rdt, 32'h0);
    @(negedge clk);
    wb.i_wb_cyc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done("t6_abort_seen", 50);
    rd_check("t6_status_after_reset", 1'b0, 32'h0000_0002);
    rd_check("t6_divisor_after_reset", 1'b1, 32'd278);
    repeat (300) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/servant_uart_tx.md
Name: servant_uart_tx

Overview:
- Wishbone-mapped hardware UART transmitter that replaces the firmware bit-banged serial pin on the servant SoC.
- Generalised over data width, FIFO depth and baud divisor. The divisor is runtime-programmable.
- Sits on the servant peripheral bus. Its serial output drives the board UART TX pin, giving buffered, CPU-independent transmission.

Parameters:
- DATA_BITS, 8, bits per character (5..9), sent LSB first.
- FIFO_DEPTH, 16, transmit FIFO entries; power of two, 2..128.
- DIV_WIDTH, 16, width of the baud divisor register.
- DEFAULT_DIV, 278, divisor reset value: clock cycles per bit (32 MHz / 115200).

Ports:
- wb_clk  input  1  system clock
- wb_rst_n  input  1  asynchronous active-low reset
- i_wb_adr  input  1  register select: 0 = data/status, 1 = divisor
- i_wb_dat  input  32  write data
- i_wb_we  input  1  write enable
- i_wb_cyc  input  1  bus cycle request
- o_wb_rdt  output  32  read data
- o_wb_ack  output  1  single-cycle acknowledge
- o_q  output  1  serial TX line, idle high

Behaviour:
- Reset (asynchronous assertion; deassertion sampled on wb_clk), forced immediately:
  - o_q=1, o_wb_ack=0, o_wb_rdt=0.
  - FIFO empty, overflow flag=0, divisor=DEFAULT_DIV, FSM=IDLE.
  - Reset mid-frame aborts the frame; the line returns high without a stop bit.
- Bus timing:
  - o_wb_ack rises the cycle after i_wb_cyc is seen with ack low, and lasts exactly one cycle.
  - A held i_wb_cyc yields acks on alternate cycles.
  - Side effects occur on the ack edge.
  - o_wb_rdt is valid with ack and is 0 otherwise.
- adr 0 write:
  - Pushes i_wb_dat[DATA_BITS-1:0] into the FIFO.
  - If the FIFO is full, the data is dropped and the overflow flag is set.
- adr 0 read returns status:
  - [0] busy: FSM not IDLE, or FIFO non-empty.
  - [1] empty.
  - [2] full.
  - [3] overflow, sticky.
  - [15:8] FIFO occupancy, zero-extended.
  - All other bits 0.
  - The read clears the overflow flag. If a full-FIFO write hits in the same cycle, set wins.
- adr 1 write: loads divisor from i_wb_dat[DIV_WIDTH-1:0].
- adr 1 read: returns the divisor, zero-extended.
- Divisor:
  - Latched into the bit timer at the start of each frame; a mid-frame write affects only the next frame.
  - A divisor value of 0 is treated as 1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_q=1. If the FIFO is non-empty, pop into the shift register, latch the divisor and go to START.
  - START: o_q=0 for DIV cycles, then DATA with bit index 0.
  - DATA: o_q=shift[0] for DIV cycles, then shift right. After DATA_BITS bits, go to STOP.
  - STOP: o_q=1 for DIV cycles. Then, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Frame length is exactly (DATA_BITS+2)*DIV cycles.
- Latency: for a write into an empty FIFO with FSM IDLE, o_q falls 2 clock edges after the ack edge.
- FIFO:
  - Circular buffer with read/write pointers and a log2(FIFO_DEPTH)+1-bit count.
  - Pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves the count unchanged and is legal when full: the pop frees a slot, so the push is accepted, not flagged as overflow.
  - Pop when empty never occurs.
- Busy stays high until the final stop bit completes.

Test Plan:
- Reset with divisor default, write 0x55 to adr 0 → o_q low 2 edges after ack. Then bits 1,0,1,0,1,0,1,0 each 278 cycles, stop bit high; frame 2780 cycles. Status reads 0x00000002 after completion.
- Set divisor=4, write 0xA3,0x0F,0xFF back-to-back → three contiguous 40-cycle frames with no idle gap. LSB-first patterns decode correctly; busy=1 until cycle 120 after first start.
- Set divisor=1, fill FIFO with 17 writes while the FSM is stalled by an in-progress frame of divisor 1000 (divisor changed after start):
  - Status shows full=1, overflow=1, count=16.
  - A second status read shows overflow=0.
  - The 17th byte is never transmitted.
- Write divisor=0, send 0x01 → each bit lasts 1 cycle, frame 10 cycles.
- Change divisor from 8 to 16 mid-frame → current frame stays 80 cycles, next frame 160 cycles. Divisor readback = 16.
- Assert wb_rst_n low mid-DATA → o_q=1 and o_wb_ack=0 asynchronously. After release, status = 0x00000002, divisor = 278, and no residual bytes are transmitted.
